// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data-memory access, branch resolution, Mem/WB register
// Loads/stores go over a req/ack bus with stall and ack timeout; branches resolve combinationally.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEMWR_Ex,
  input  logic        MEM2REG_Ex,
  input  logic        REGWR_Ex,
  input  logic        BRANCH_Ex,
  input  logic        BRANCHNE_Ex,
  input  logic        JUMP_Ex,
  input  logic        JCALL_Ex,
  input  logic        JRETURN_Ex,
  input  logic        zero,
  input  logic [31:0] ALUout,
  input  logic [31:0] tran_addr,
  input  logic [4:0]  regwr,
  input  logic [31:0] reg_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        JUMPEN,
  output logic [31:0] jump_target,
  output logic        stall_req,
  output logic [4:0]  dest_reg_Mem,
  output logic [31:0] dest_regdata_Mem,
  output logic        REGWR_Mem,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  // Abort fires on the last WAIT cycle so the whole stall lasts ACK_TIMEOUT cycles.
  localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

  logic [0:0]  state;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;

  logic mem_op;
  logic mis;
  logic in_idle;
  logic in_wait;
  logic issue;
  logic abort;
  logic is_load;
  logic take;

  always_comb begin
    mem_op  = MEMWR_Ex | MEM2REG_Ex;
    mis     = mem_op & (ALUout[1:0] != 2'b00);
    in_idle = (state == S_IDLE);
    in_wait = (state == S_WAIT);
    issue   = in_idle & mem_op & ~mis;
    abort   = in_wait & ~dmem_ack & (cnt == LAST_CNT);
    is_load = MEM2REG_Ex & ~MEMWR_Ex;
    take    = (BRANCH_Ex & zero) | (BRANCHNE_Ex & ~zero) | JUMP_Ex | JCALL_Ex | JRETURN_Ex;
  end

  // Bus outputs come from the latched request while waiting so they stay stable.
  always_comb begin
    dmem_req   = rst_n & (issue | in_wait);
    dmem_we    = in_wait ? we_q    : MEMWR_Ex;
    dmem_addr  = in_wait ? addr_q  : ALUout;
    dmem_wdata = in_wait ? wdata_q : reg_data;
    stall_req  = rst_n & ~dmem_ack & (issue | (in_wait & ~abort));
  end

  always_comb begin
    JUMPEN      = rst_n & in_idle & take;
    jump_target = JRETURN_Ex ? reg_data : tran_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue && !dmem_ack) begin
            state   <= S_WAIT;
            cnt     <= 8'd0;
            addr_q  <= ALUout;
            wdata_q <= reg_data;
            we_q    <= MEMWR_Ex;
          end
        end
        S_WAIT: begin
          if (dmem_ack || abort) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Mem/WB register: a stalled cycle inserts a bubble, otherwise the result retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_reg_Mem     <= 5'd0;
      dest_regdata_Mem <= 32'd0;
      REGWR_Mem        <= 1'b0;
    end else if (stall_req) begin
      REGWR_Mem <= 1'b0;
    end else begin
      dest_reg_Mem     <= regwr;
      dest_regdata_Mem <= is_load ? dmem_rdata : ALUout;
      REGWR_Mem        <= REGWR_Ex & ~mis & ~abort & (regwr != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      align_err <= in_idle & mis;
      if (abort) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a Mem/WB scoreboard
module tb_mem_stage;

  localparam int TMO = 255;

  logic        clk;
  logic        rst_n;
  logic        MEMWR_Ex, MEM2REG_Ex, REGWR_Ex, BRANCH_Ex, BRANCHNE_Ex;
  logic        JUMP_Ex, JCALL_Ex, JRETURN_Ex, zero;
  logic [31:0] ALUout, tran_addr, reg_data;
  logic [4:0]  regwr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        JUMPEN, stall_req, REGWR_Mem, align_err, bus_err;
  logic [31:0] jump_target, dest_regdata_Mem;
  logic [4:0]  dest_reg_Mem;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wr;
  } wb_t;

  wb_t sb[$];
  wb_t e;
  int  total = 0;
  int  bad   = 0;

  mem_stage #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEMWR_Ex(MEMWR_Ex), .MEM2REG_Ex(MEM2REG_Ex), .REGWR_Ex(REGWR_Ex),
    .BRANCH_Ex(BRANCH_Ex), .BRANCHNE_Ex(BRANCHNE_Ex), .JUMP_Ex(JUMP_Ex),
    .JCALL_Ex(JCALL_Ex), .JRETURN_Ex(JRETURN_Ex), .zero(zero),
    .ALUout(ALUout), .tran_addr(tran_addr), .regwr(regwr), .reg_data(reg_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .JUMPEN(JUMPEN), .jump_target(jump_target), .stall_req(stall_req),
    .dest_reg_Mem(dest_reg_Mem), .dest_regdata_Mem(dest_regdata_Mem),
    .REGWR_Mem(REGWR_Mem), .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    MEMWR_Ex = 0; MEM2REG_Ex = 0; REGWR_Ex = 0; BRANCH_Ex = 0; BRANCHNE_Ex = 0;
    JUMP_Ex = 0; JCALL_Ex = 0; JRETURN_Ex = 0; zero = 0;
    ALUout = 0; tran_addr = 0; regwr = 0; reg_data = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    JUMP_Ex = 1;
    rst_n = 0;
    #12;
    total++;
    if (dest_reg_Mem !== 5'd0 || dest_regdata_Mem !== 32'd0 || REGWR_Mem !== 1'b0 ||
        bus_err !== 1'b0 || align_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got rd=%0d data=%h wr=%b bus=%b al=%b, want all 0",
               dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, bus_err, align_err);
    end
    total++;
    if (dmem_req !== 1'b0 || stall_req !== 1'b0 || JUMPEN !== 1'b0) begin
      bad++;
      $display("FAIL reset_comb: got req=%b stall=%b jumpen=%b, want 0 0 0", dmem_req, stall_req, JUMPEN);
    end
    JUMP_Ex = 0;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    clear_inputs();
    ALUout = 32'h12; regwr = 5'd3; REGWR_Ex = 1;
    sb.push_back('{5'd3, 32'h12, 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
      bad++;
      $display("FAIL alu_add: got rd=%0d data=%h wr=%b, want rd=%0d data=%h wr=%b",
               dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
    end
    ALUout = 32'h99; regwr = 5'd0; REGWR_Ex = 1;
    sb.push_back('{5'd0, 32'h99, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
      bad++;
      $display("FAIL alu_r0: got rd=%0d data=%h wr=%b, want rd=%0d data=%h wr=%b",
               dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
    end
    clear_inputs();
  endtask

  task automatic test_load_wait();
    logic bubble_bad;
    clear_inputs();
    MEM2REG_Ex = 1; REGWR_Ex = 1; ALUout = 32'h100; regwr = 5'd5;
    sb.push_back('{5'd5, 32'hDEADBEEF, 1'b1});
    bubble_bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dmem_req !== 1'b1 || stall_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0)
        bubble_bad = 1;
      @(posedge clk); #1;
      if (REGWR_Mem !== 1'b0) bubble_bad = 1;
    end
    total++;
    if (bubble_bad) begin
      bad++;
      $display("FAIL load_wait_stall: req/stall/addr/bubble wrong during wait (req=%b stall=%b addr=%h wr=%b)",
               dmem_req, stall_req, dmem_addr, REGWR_Mem);
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("FAIL load_ack_stall: got stall=%b, want 0", stall_req);
    end
    @(posedge clk); #1;
    clear_inputs();
    e = sb.pop_front();
    total++;
    if (dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
      bad++;
      $display("FAIL load_wb: got rd=%0d data=%h wr=%b, want rd=%0d data=%h wr=%b",
               dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
    end
  endtask

  task automatic test_store_hold();
    clear_inputs();
    MEMWR_Ex = 1; ALUout = 32'h104; reg_data = 32'hCAFE0001; regwr = 5'd9;
    sb.push_back('{5'd9, 32'h104, 1'b0});
    @(posedge clk); #1;
    reg_data = 32'h0;
    #1;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'hCAFE0001 || dmem_addr !== 32'h104) begin
      bad++;
      $display("FAIL store_hold: got req=%b we=%b addr=%h wdata=%h, want 1 1 00000104 cafe0001",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1;
    @(posedge clk); #1;
    clear_inputs();
    e = sb.pop_front();
    total++;
    if (dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
      bad++;
      $display("FAIL store_wb: got rd=%0d data=%h wr=%b, want rd=%0d data=%h wr=%b",
               dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
    end
  endtask

  task automatic test_misaligned();
    clear_inputs();
    MEMWR_Ex = 1; ALUout = 32'h102; regwr = 5'd4; REGWR_Ex = 1;
    sb.push_back('{5'd4, 32'h102, 1'b0});
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL mis_noreq: got req=%b stall=%b, want 0 0", dmem_req, stall_req);
    end
    @(posedge clk); #1;
    clear_inputs();
    e = sb.pop_front();
    total++;
    if (align_err !== 1'b1 || dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
      bad++;
      $display("FAIL mis_wb: got al=%b rd=%0d data=%h wr=%b, want al=1 rd=%0d data=%h wr=%b",
               align_err, dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
    end
    @(posedge clk); #1;
    total++;
    if (align_err !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse: got al=%b, want 0", align_err);
    end
  endtask

  task automatic test_branch();
    // beq bne j jal jr zero tran reg_data exp_en exp_tgt
    logic [3:0][0:0] dummy;
    logic [9:0]  flags [7];
    logic [31:0] tr [7];
    logic [31:0] rd [7];
    logic [31:0] tg [7];
    flags[0] = 10'b10000_1_0000; tr[0] = 32'h40;   rd[0] = 32'h0;  tg[0] = 32'h40;
    flags[1] = 10'b10000_0_0000; tr[1] = 32'h40;   rd[1] = 32'h0;  tg[1] = 32'h0;
    flags[2] = 10'b01000_0_0000; tr[2] = 32'h44;   rd[2] = 32'h0;  tg[2] = 32'h44;
    flags[3] = 10'b01000_1_0000; tr[3] = 32'h44;   rd[3] = 32'h0;  tg[3] = 32'h0;
    flags[4] = 10'b00001_0_0000; tr[4] = 32'h99;   rd[4] = 32'h80; tg[4] = 32'h80;
    flags[5] = 10'b00100_0_0000; tr[5] = 32'h1000; rd[5] = 32'h0;  tg[5] = 32'h1000;
    flags[6] = 10'b00010_1_0000; tr[6] = 32'h2000; rd[6] = 32'h0;  tg[6] = 32'h2000;
    dummy = '0;
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      BRANCH_Ex = flags[i][9]; BRANCHNE_Ex = flags[i][8]; JUMP_Ex = flags[i][7];
      JCALL_Ex = flags[i][6]; JRETURN_Ex = flags[i][5]; zero = flags[i][4];
      tran_addr = tr[i]; reg_data = rd[i];
      if (JCALL_Ex) begin
        ALUout = 32'h20; regwr = 5'd31; REGWR_Ex = 1;
        sb.push_back('{5'd31, 32'h20, 1'b1});
      end
      #1;
      total++;
      if (JUMPEN !== (tg[i] != 32'h0) || (tg[i] != 32'h0 && jump_target !== tg[i])) begin
        bad++;
        $display("FAIL branch_%0d: got en=%b tgt=%h, want en=%b tgt=%h",
                 i, JUMPEN, jump_target, (tg[i] != 32'h0), tg[i]);
      end
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
          bad++;
          $display("FAIL jal_link: got rd=%0d data=%h wr=%b, want rd=%0d data=%h wr=%b",
                   dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int  n;
    logic bubble_bad;
    clear_inputs();
    MEM2REG_Ex = 1; REGWR_Ex = 1; ALUout = 32'h300; regwr = 5'd6;
    n = 0;
    bubble_bad = 0;
    #1;
    while (stall_req === 1'b1 && n < 400) begin
      n++;
      @(posedge clk); #2;
      if (REGWR_Mem !== 1'b0) bubble_bad = 1;
    end
    total++;
    if (n != TMO || bubble_bad) begin
      bad++;
      $display("FAIL timeout_stall: got %0d stall cycles bubble_bad=%b, want %0d and 0", n, bubble_bad, TMO);
    end
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pre: got bus_err=%b, want 0", bus_err);
    end
    sb.push_back('{5'd6, 32'h0, 1'b0});
    @(posedge clk); #1;
    clear_inputs();
    e = sb.pop_front();
    total++;
    if (bus_err !== 1'b1 || dest_reg_Mem !== e.rd || REGWR_Mem !== e.wr) begin
      bad++;
      $display("FAIL timeout_abort: got bus=%b rd=%0d wr=%b, want bus=1 rd=%0d wr=%b",
               bus_err, dest_reg_Mem, REGWR_Mem, e.rd, e.wr);
    end
    @(posedge clk); #1;
    total++;
    if (bus_err !== 1'b1 || stall_req !== 1'b0) begin
      bad++;
      $display("FAIL bus_err_sticky: got bus=%b stall=%b, want 1 0", bus_err, stall_req);
    end
  endtask

  task automatic test_reset_wait();
    clear_inputs();
    MEM2REG_Ex = 1; REGWR_Ex = 1; ALUout = 32'h400; regwr = 5'd2;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_req !== 1'b0 || REGWR_Mem !== 1'b0 || bus_err !== 1'b0 ||
        dest_reg_Mem !== 5'd0) begin
      bad++;
      $display("FAIL reset_wait: got req=%b stall=%b wr=%b bus=%b rd=%0d, want all 0",
               dmem_req, stall_req, REGWR_Mem, bus_err, dest_reg_Mem);
    end
    clear_inputs();
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 1'b0 || REGWR_Mem !== 1'b0) begin
      bad++;
      $display("FAIL reset_abandon: got req=%b wr=%b, want 0 0", dmem_req, REGWR_Mem);
    end
  endtask

  task automatic test_back_to_back();
    // wr2reg, load, store, rd, alu
    logic        ld [5];
    logic        st [5];
    logic        rw [5];
    logic [4:0]  rdn [5];
    logic [31:0] alu [5];
    logic [31:0] rdat;
    ld[0] = 0; st[0] = 0; rw[0] = 1; rdn[0] = 5'd10; alu[0] = 32'h55;
    ld[1] = 1; st[1] = 0; rw[1] = 1; rdn[1] = 5'd11; alu[1] = 32'h500;
    ld[2] = 0; st[2] = 0; rw[2] = 1; rdn[2] = 5'd0;  alu[2] = 32'h77;
    ld[3] = 1; st[3] = 1; rw[3] = 1; rdn[3] = 5'd12; alu[3] = 32'h600;
    ld[4] = 0; st[4] = 0; rw[4] = 1; rdn[4] = 5'd13; alu[4] = $urandom & 32'hFFFFFFFC;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      MEM2REG_Ex = ld[i]; MEMWR_Ex = st[i]; REGWR_Ex = rw[i]; regwr = rdn[i]; ALUout = alu[i];
      rdat = $urandom;
      if (ld[i] || st[i]) begin
        dmem_ack = 1; dmem_rdata = rdat;
      end
      sb.push_back('{rdn[i], (ld[i] && !st[i]) ? rdat : alu[i], rw[i] && (rdn[i] != 5'd0)});
      #1;
      total++;
      if (stall_req !== 1'b0 || dmem_req !== (ld[i] | st[i]) || ((ld[i] | st[i]) && dmem_we !== st[i])) begin
        bad++;
        $display("FAIL b2b_bus_%0d: got stall=%b req=%b we=%b, want 0 %b %b",
                 i, stall_req, dmem_req, dmem_we, ld[i] | st[i], st[i]);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (dest_reg_Mem !== e.rd || dest_regdata_Mem !== e.data || REGWR_Mem !== e.wr) begin
        bad++;
        $display("FAIL b2b_wb_%0d: got rd=%0d data=%h wr=%b, want rd=%0d data=%h wr=%b",
                 i, dest_reg_Mem, dest_regdata_Mem, REGWR_Mem, e.rd, e.data, e.wr);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_hold();
    test_misaligned();
    test_branch();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
